led_pattern_driver: RTL and testbench

- Consumes the free-running blink clock `flashclk` from the LED flash/PWM generator; both blocks are clocked by the same `clk`.
- Drives NUM_LED board LEDs.
- Each LED has a software-selected mode: off, on, blink, or blink-code. In blink-code mode the LED emits N pulses, goes dark for a gap, then repeats; this is used for status and error codes.
- Sits between the register/control logic and the LED pins.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_code_fsm.sv | 102 ++++++++++
 rtl/led_pattern_driver.sv | 65 ++++++
 tb/tb_led_pattern_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern driver: mode encodings, the
// blink-code FSM state type and the gap counter width.
package led_pkg;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_CODE  = 2'b11;

   // Gap counter is 8 bits so GAP_PERIODS can span 1..255 without wrap.
   localparam int GAP_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLINK = 2'd1,
      GAP   = 2'd2
   } code_st_t;

endpackage

// File: rtl/led_code_fsm.sv
// Per-LED channel: mode decode plus the blink-code sequencer
// (N pulses, GAP_PERIODS dark periods, repeat). Outputs are the
// next-cycle LED level and busy flag; the top registers them.
module led_code_fsm
   import led_pkg::*;
#(
   parameter int CODE_W      = 4,
   parameter int GAP_PERIODS = 3
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              flash_d,
   input  logic [1:0]        mode,
   input  logic [CODE_W-1:0] code,
   output logic              led,
   output logic              busy
);

   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_PERIODS);

   code_st_t          state, state_nxt;
   logic [CODE_W-1:0] code_lat, code_lat_nxt;
   logic [CODE_W-1:0] blink_cnt, blink_cnt_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         code_lat  <= '0;
         blink_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         code_lat  <= code_lat_nxt;
         blink_cnt <= blink_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
      end
   end

   // Next state: advances only on tick; leaving code mode aborts to IDLE at once.
   always_comb begin
      state_nxt     = state;
      code_lat_nxt  = code_lat;
      blink_cnt_nxt = blink_cnt;
      gap_cnt_nxt   = gap_cnt;
      if (mode != MODE_CODE) begin
         state_nxt     = IDLE;
         code_lat_nxt  = '0;
         blink_cnt_nxt = '0;
         gap_cnt_nxt   = '0;
      end else if (tick) begin
         case (state)
            IDLE: begin
               if (code != '0) begin
                  code_lat_nxt  = code;
                  blink_cnt_nxt = CODE_W'(1);
                  state_nxt     = BLINK;
               end
            end
            BLINK: begin
               if (blink_cnt == code_lat) begin
                  gap_cnt_nxt = GAP_W'(1);
                  state_nxt   = GAP;
               end else begin
                  blink_cnt_nxt = blink_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_END) begin
                  // Burst boundary: the only place besides IDLE where code is re-sampled.
                  if (code == '0) begin
                     state_nxt = IDLE;
                  end else begin
                     code_lat_nxt  = code;
                     blink_cnt_nxt = CODE_W'(1);
                     state_nxt     = BLINK;
                  end
               end else begin
                  gap_cnt_nxt = gap_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // LED level from mode and current state; busy tracks the state being loaded.
   always_comb begin
      led = 1'b0;
      case (mode)
         MODE_OFF:   led = 1'b0;
         MODE_ON:    led = 1'b1;
         MODE_BLINK: led = flash_d;
         MODE_CODE:  led = (state == BLINK) & flash_d;
         default:    led = 1'b0;
      endcase
      busy = (state_nxt != IDLE);
   end

endmodule

// File: rtl/led_pattern_driver.sv
// LED pattern driver: per-LED off/on/blink/blink-code from a shared
// flashclk phase. All channels share flash_d and tick so blinking stays
// phase-locked. Define LED_INVERT_EN for active-low (sink) LED outputs.
module led_pattern_driver
   import led_pkg::*;
#(
   parameter int NUM_LED     = 4,
   parameter int CODE_W      = 4,
   parameter int GAP_PERIODS = 3
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flashclk,
   input  logic [2*NUM_LED-1:0]       mode,
   input  logic [CODE_W*NUM_LED-1:0]  code,
   output logic [NUM_LED-1:0]         led_out,
   output logic [NUM_LED-1:0]         code_busy
);

`ifdef LED_INVERT_EN
   localparam logic [NUM_LED-1:0] LED_POL = '1;
`else
   localparam logic [NUM_LED-1:0] LED_POL = '0;
`endif

   logic               flash_d;
   logic               tick;
   logic [NUM_LED-1:0] led_c;
   logic [NUM_LED-1:0] busy_c;

   assign tick = flashclk & ~flash_d;

   genvar g;
   generate
      for (g = 0; g < NUM_LED; g++) begin : g_ch
         led_code_fsm #(
            .CODE_W      (CODE_W),
            .GAP_PERIODS (GAP_PERIODS)
         ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .flash_d (flash_d),
            .mode    (mode[2*g +: 2]),
            .code    (code[CODE_W*g +: CODE_W]),
            .led     (led_c[g]),
            .busy    (busy_c[g])
         );
      end
   endgenerate

   // Flash phase delay and output register with optional polarity flip.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flash_d   <= 1'b0;
         led_out   <= LED_POL;
         code_busy <= '0;
      end else begin
         flash_d   <= flashclk;
         led_out   <= led_c ^ LED_POL;
         code_busy <= busy_c;
      end
   end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Scoreboard bench for led_pattern_driver: each cycle the expected
// outputs are pushed when inputs are driven and popped at the next negedge.
module tb_led_pattern_driver;

   localparam int NL = 4;
   localparam int CW = 4;
   localparam int GP = 3;

`ifdef LED_INVERT_EN
   localparam logic [NL-1:0] RST_LED = '1;
`else
   localparam logic [NL-1:0] RST_LED = '0;
`endif

   typedef struct packed {
      logic [NL-1:0] led;
      logic [NL-1:0] busy;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              flashclk = 1'b0;
   logic [2*NL-1:0]   mode = '0;
   logic [CW*NL-1:0]  code = '0;
   logic [NL-1:0]     led_out;
   logic [NL-1:0]     code_busy;

   // shadows applied at the next negedge
   logic [2*NL-1:0]   mode_n = '0;
   logic [CW*NL-1:0]  code_n = '0;
   logic              rst_n_n = 1'b0;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   fph = 0;
   bit   stuck = 0, stuck_val = 0;
   bit   fh0 = 0, fh1 = 0;
   bit   chk_b2 = 0;

   // reference: per-LED sequence position in flashclk periods
   bit   m_fd = 0;
   bit   m_act[NL];
   int   m_ph[NL];
   int   m_n[NL];

   led_pattern_driver #(.NUM_LED(NL), .CODE_W(CW), .GAP_PERIODS(GP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flashclk  (flashclk),
      .mode      (mode),
      .code      (code),
      .led_out   (led_out),
      .code_busy (code_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_clr();
      m_fd = 0;
      for (int i = 0; i < NL; i++) begin
         m_act[i] = 0; m_ph[i] = 0; m_n[i] = 0;
      end
   endtask

   // compute outputs after the coming edge from current inputs
   task automatic model();
      exp_t e;
      bit   tk;
      logic [1:0]    m;
      logic [CW-1:0] c;
      tk = flashclk & ~m_fd;
      for (int i = 0; i < NL; i++) begin
         m = mode[2*i +: 2];
         c = code[CW*i +: CW];
         case (m)
            2'b00: e.led[i] = 1'b0;
            2'b01: e.led[i] = 1'b1;
            2'b10: e.led[i] = m_fd;
            default: e.led[i] = (m_act[i] && m_ph[i] < m_n[i]) ? m_fd : 1'b0;
         endcase
         if (m != 2'b11) begin
            m_act[i] = 0;
         end else if (tk) begin
            if (!m_act[i]) begin
               if (c != 0) begin
                  m_act[i] = 1; m_n[i] = int'(c); m_ph[i] = 0;
               end
            end else begin
               m_ph[i]++;
               if (m_ph[i] == m_n[i] + GP) begin
                  if (c == 0) m_act[i] = 0;
                  else begin
                     m_n[i] = int'(c); m_ph[i] = 0;
                  end
               end
            end
         end
         e.busy[i] = m_act[i];
      end
      e.led = e.led ^ RST_LED;
      m_fd = flashclk;
      q.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      bit   fc;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("led_out", led_out, e.led);
         chk("code_busy", code_busy, e.busy);
      end
      if (chk_b2) chk("blink_delay2", led_out[2] ^ RST_LED[2], fh1);
      fc  = stuck ? stuck_val : (fph < 4);
      fph = (fph + 1) % 8;
      fh1 = fh0; fh0 = fc;
      flashclk = fc;
      mode     = mode_n;
      code     = code_n;
      rst_n    = rst_n_n;
      if (rst_n) model();
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      rst_n_n = 1'b0;
      #1;
      chk("rst_led", led_out, RST_LED);
      chk("rst_busy", code_busy, '0);
      q.delete();
      model_clr();
      repeat (3) step();
      rst_n_n = 1'b1;
   endtask

   initial begin
      int  highs;
      bit  saw;
      logic [NL-1:0] held;
      model_clr();
      #1 rst_n = 1'b0;
      #1;
      chk("init_rst_led", led_out, RST_LED);
      chk("init_rst_busy", code_busy, '0);
      repeat (2) step();
      rst_n_n = 1'b1;

      // static modes: LED3 code(0), LED2 blink, LED1 on, LED0 off
      mode_n = {2'b11, 2'b10, 2'b01, 2'b00};
      code_n = '0;
      repeat (3) step();
      chk_b2 = 1;
      repeat (24) step();
      chk_b2 = 0;

      // code burst, LED0 count 2
      mode_n = 8'b00_00_00_11;
      code_n = 16'h0002;
      repeat (20) step();
      highs = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         highs += int'(led_out[0] ^ RST_LED[0]);
         chk("burst_busy", code_busy[0], 1'b1);
      end
      chk("burst_on_cycles", highs, 8);
      repeat (20) step();

      // mid-burst code change 3 -> 1
      mode_n = '0;
      repeat (2) step();
      mode_n = 8'b00_00_00_11;
      code_n = 16'h0003;
      repeat (14) step();
      code_n = 16'h0001;
      repeat (90) step();

      // abort during GAP, then restart
      code_n = 16'h0002;
      for (int k = 0; k < 100; k++) begin
         if (m_act[0] && m_ph[0] >= m_n[0]) break;
         step();
      end
      chk("reached_gap", m_act[0] && m_ph[0] >= m_n[0], 1'b1);
      mode_n = '0;
      repeat (4) step();
      mode_n = 8'b00_00_00_11;
      saw = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (led_out[0] ^ RST_LED[0]) saw = 1;
      end
      chk("restart_pulse", saw, 1'b1);

      // stuck flashclk high
      code_n = 16'h0005;
      repeat (30) step();
      stuck = 1; stuck_val = 1;
      repeat (3) step();
      held = led_out;
      repeat (100) step();
      chk("stuck_hold", led_out, held);
      stuck = 0;
      repeat (20) step();

      // mid-run async reset with all LEDs in code mode
      mode_n = 8'hFF;
      code_n = 16'h1234;
      repeat (30) step();
      do_reset();
      repeat (40) step();
      mode_n = '0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
